// File: rtl/writeback_unit_pkg.sv
// Shared types and constants for the writeback unit and its result FIFO.
package writeback_unit_pkg;

   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] word_t;

   typedef enum logic {
      LdIdle,
      LdWait
   } ld_state_e;

   localparam reg_addr_t ZERO_REG = 5'd0;

   // Register 0 is hardwired, so it never participates in a dependency.
   function automatic logic src_hit(reg_addr_t src, reg_addr_t dest);
      return (src != ZERO_REG) && (src == dest);
   endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// ALU result queue: DEPTH entries of {dest, data} with an explicit occupancy count,
// plus a per-entry destination match against two decode-stage source registers.
module wb_result_fifo
   import writeback_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      i_push,
   input  reg_addr_t i_push_dest,
   input  word_t     i_push_data,
   input  logic      i_pop,
   input  reg_addr_t i_rs_addr,
   input  reg_addr_t i_rt_addr,
   output logic      o_full,
   output logic      o_empty,
   output reg_addr_t o_head_dest,
   output word_t     o_head_data,
   output logic      o_src_hit
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [DEPTH-1:0] r_valid;
   reg_addr_t        r_dest [DEPTH];
   word_t            r_data [DEPTH];

   logic w_push;
   logic w_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign o_full      = (r_count == CNT_W'(DEPTH));
   assign o_empty     = (r_count == '0);
   assign w_push      = i_push && !o_full;
   assign w_pop       = i_pop && !o_empty;
   assign o_head_dest = r_dest[r_rd_ptr];
   assign o_head_data = r_data[r_rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr          <= ptr_inc(r_wr_ptr);
            r_valid[r_wr_ptr] <= 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr          <= ptr_inc(r_rd_ptr);
            r_valid[r_rd_ptr] <= 1'b0;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage needs no reset; r_valid qualifies every read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_dest[r_wr_ptr] <= i_push_dest;
         r_data[r_wr_ptr] <= i_push_data;
      end
   end

   always_comb begin
      o_src_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i] && (src_hit(i_rs_addr, r_dest[i]) || src_hit(i_rt_addr, r_dest[i]))) begin
            o_src_hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/writeback_unit.sv
// Writeback arbiter: merges load responses and queued ALU results onto one registered
// register-file write port. Define WB_FORWARD_EN to enable the write-port bypass outputs.
module writeback_unit
   import writeback_unit_pkg::*;
#(
   parameter int unsigned ALU_Q_DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      alu_valid,
   input  reg_addr_t alu_dest,
   input  word_t     alu_data,
   output logic      alu_ready,
   input  logic      load_issue,
   input  reg_addr_t load_issue_dest,
   output logic      load_issue_ready,
   input  logic      load_valid,
   input  word_t     load_data,
   input  reg_addr_t rsAddress,
   input  reg_addr_t rtAddress,
   output logic      hazard,
   output logic      registerWrite,
   output reg_addr_t writeAddress,
   output word_t     writeData,
   output logic      fwd_hit0,
   output logic      fwd_hit1,
   output word_t     fwd_data0,
   output word_t     fwd_data1
);

   ld_state_e r_ld_state;
   ld_state_e w_ld_state_next;
   reg_addr_t r_ld_dest;
   logic      w_ld_capture;
   logic      w_ld_done;

   logic      w_fifo_full;
   logic      w_fifo_empty;
   reg_addr_t w_head_dest;
   word_t     w_head_data;
   logic      w_fifo_hit;

   logic      r_wr_en;
   reg_addr_t r_wr_addr;
   word_t     r_wr_data;
   logic      w_wr_en;
   reg_addr_t w_wr_addr;
   word_t     w_wr_data;

   assign w_ld_done        = (r_ld_state == LdWait) && load_valid;
   assign load_issue_ready = (r_ld_state == LdIdle);
   assign alu_ready        = !w_fifo_full;

   always_comb begin
      w_ld_state_next = r_ld_state;
      w_ld_capture    = 1'b0;
      unique case (r_ld_state)
         LdIdle: begin
            if (load_issue) begin
               w_ld_state_next = LdWait;
               w_ld_capture    = 1'b1;
            end
         end
         LdWait: begin
            if (load_valid) begin
               w_ld_state_next = LdIdle;
            end
         end
         default: w_ld_state_next = LdIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ld_state <= LdIdle;
         r_ld_dest  <= ZERO_REG;
      end else begin
         r_ld_state <= w_ld_state_next;
         if (w_ld_capture) begin
            r_ld_dest <= load_issue_dest;
         end
      end
   end

   // The queue head only advances in cycles the load response does not claim.
   wb_result_fifo #(
      .DEPTH (ALU_Q_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (alu_valid),
      .i_push_dest (alu_dest),
      .i_push_data (alu_data),
      .i_pop       (!w_ld_done),
      .i_rs_addr   (rsAddress),
      .i_rt_addr   (rtAddress),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty),
      .o_head_dest (w_head_dest),
      .o_head_data (w_head_data),
      .o_src_hit   (w_fifo_hit)
   );

   // Results for r0 are consumed without a write pulse.
   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_addr = r_wr_addr;
      w_wr_data = r_wr_data;
      if (w_ld_done) begin
         if (r_ld_dest != ZERO_REG) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_ld_dest;
            w_wr_data = load_data;
         end
      end else if (!w_fifo_empty && (w_head_dest != ZERO_REG)) begin
         w_wr_en   = 1'b1;
         w_wr_addr = w_head_dest;
         w_wr_data = w_head_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= ZERO_REG;
         r_wr_data <= '0;
      end else begin
         r_wr_en   <= w_wr_en;
         r_wr_addr <= w_wr_addr;
         r_wr_data <= w_wr_data;
      end
   end

   assign registerWrite = r_wr_en;
   assign writeAddress  = r_wr_addr;
   assign writeData     = r_wr_data;

   assign hazard = w_fifo_hit ||
                   ((r_ld_state == LdWait) &&
                    (src_hit(rsAddress, r_ld_dest) || src_hit(rtAddress, r_ld_dest)));

`ifdef WB_FORWARD_EN
   assign fwd_hit0  = r_wr_en && src_hit(rsAddress, r_wr_addr);
   assign fwd_hit1  = r_wr_en && src_hit(rtAddress, r_wr_addr);
   assign fwd_data0 = fwd_hit0 ? r_wr_data : '0;
   assign fwd_data1 = fwd_hit1 ? r_wr_data : '0;
`else
   assign fwd_hit0  = 1'b0;
   assign fwd_hit1  = 1'b0;
   assign fwd_data0 = '0;
   assign fwd_data1 = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: arbitration, FIFO back-pressure, load FSM, reset, bypass.
module tb_writeback_unit;

   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_dest;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        load_issue;
   logic [4:0]  load_issue_dest;
   logic        load_issue_ready;
   logic        load_valid;
   logic [31:0] load_data;
   logic [4:0]  rsAddress;
   logic [4:0]  rtAddress;
   logic        hazard;
   logic        registerWrite;
   logic [4:0]  writeAddress;
   logic [31:0] writeData;
   logic        fwd_hit0;
   logic        fwd_hit1;
   logic [31:0] fwd_data0;
   logic [31:0] fwd_data1;

   int n_vec = 0;
   int n_err = 0;

   logic [36:0] wq [$];
   logic [36:0] exp_d [7] = '{
      {5'd20, 32'h0000_00D0}, {5'd10, 32'h0000_00A0}, {5'd21, 32'h0000_00D1},
      {5'd11, 32'h0000_00B1}, {5'd22, 32'h0000_00D2}, {5'd12, 32'h0000_00C2},
      {5'd13, 32'h0000_00D3}
   };
   logic        exp_fwd_hit;
   logic [31:0] exp_fwd_data;

   writeback_unit #(
      .ALU_Q_DEPTH (2)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .alu_valid        (alu_valid),
      .alu_dest         (alu_dest),
      .alu_data         (alu_data),
      .alu_ready        (alu_ready),
      .load_issue       (load_issue),
      .load_issue_dest  (load_issue_dest),
      .load_issue_ready (load_issue_ready),
      .load_valid       (load_valid),
      .load_data        (load_data),
      .rsAddress        (rsAddress),
      .rtAddress        (rtAddress),
      .hazard           (hazard),
      .registerWrite    (registerWrite),
      .writeAddress     (writeAddress),
      .writeData        (writeData),
      .fwd_hit0         (fwd_hit0),
      .fwd_hit1         (fwd_hit1),
      .fwd_data0        (fwd_data0),
      .fwd_data1        (fwd_data1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Each write pulse lasts one cycle, so one mid-cycle sample captures it once.
   always @(negedge clk) begin
      if (registerWrite) wq.push_back({writeAddress, writeData});
   end

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
      n_vec++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
      load_issue = 1'b0; load_issue_dest = '0;
      load_valid = 1'b0; load_data = '0;
      rsAddress = '0; rtAddress = '0;
`ifdef WB_FORWARD_EN
      exp_fwd_hit = 1'b1; exp_fwd_data = 32'h0000_0099;
`else
      exp_fwd_hit = 1'b0; exp_fwd_data = 32'h0;
`endif

      // Reset state
      #2;
      chk("rst_wr", registerWrite, 0);
      chk("rst_waddr", writeAddress, 0);
      chk("rst_wdata", writeData, 0);
      chk("rst_hazard", hazard, 0);
      chk("rst_alu_ready", alu_ready, 1);
      chk("rst_ld_ready", load_issue_ready, 1);
      chk("rst_fwd", {fwd_hit0, fwd_hit1, fwd_data0}, 0);
      chk("rst_fwd_d1", fwd_data1, 0);
      #10 rst = 1'b1;
      tick();

      // ALU result latency: offer in cycle 0, write in cycle 2
      alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'h1234;
      #1 chk("a_ready", alu_ready, 1);
      tick();
      alu_valid = 1'b0; rsAddress = 5'd5;
      #1 chk("a_c1_wr", registerWrite, 0);
      chk("a_c1_hazard", hazard, 1);
      tick();
      chk("a_c2_wr", registerWrite, 1);
      chk("a_c2_addr", writeAddress, 5);
      chk("a_c2_data", writeData, 32'h1234);
      chk("a_c2_hazard", hazard, 0);
      tick();
      chk("a_c3_wr", registerWrite, 0);
      rsAddress = '0;

      // Load hazard and completion; issue during WAIT ignored
      load_issue = 1'b1; load_issue_dest = 5'd7; rsAddress = 5'd7;
      #1 chk("b_idle_hazard", hazard, 0);
      chk("b_idle_ready", load_issue_ready, 1);
      tick();
      load_issue_dest = 5'd8;
      #1 chk("b_wait_hazard", hazard, 1);
      chk("b_wait_ready", load_issue_ready, 0);
      tick();
      load_issue = 1'b0; rsAddress = 5'd0; rtAddress = 5'd7;
      #1 chk("b_rt_hazard", hazard, 1);
      rsAddress = 5'd8; rtAddress = 5'd0;
      #1 chk("b_r8_hazard", hazard, 0);
      rsAddress = 5'd7; load_valid = 1'b1; load_data = 32'hCAFE;
      #1 chk("b_resp_hazard", hazard, 1);
      tick();
      load_valid = 1'b0;
      #1 chk("b_wr", registerWrite, 1);
      chk("b_addr", writeAddress, 7);
      chk("b_data", writeData, 32'hCAFE);
      chk("b_after_hazard", hazard, 0);
      chk("b_after_ready", load_issue_ready, 1);
      rsAddress = '0;
      load_valid = 1'b1; load_data = 32'hDEAD;
      tick();
      load_valid = 1'b0;
      #1 chk("b_stray_wr", registerWrite, 0);

      // Load response beats queued ALU r3; same-cycle issue ignored
      load_issue = 1'b1; load_issue_dest = 5'd4;
      alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'h33;
      tick();
      alu_valid = 1'b0; load_issue_dest = 5'd6;
      load_valid = 1'b1; load_data = 32'h44;
      tick();
      load_issue = 1'b0; load_valid = 1'b0; rsAddress = 5'd6;
      #1 chk("c_wr1", {registerWrite, writeAddress, writeData}, {1'b1, 5'd4, 32'h44});
      chk("c_ld_ready", load_issue_ready, 1);
      chk("c_r6_hazard", hazard, 0);
      rsAddress = '0;
      tick();
      chk("c_wr2", {registerWrite, writeAddress, writeData}, {1'b1, 5'd3, 32'h33});
      tick();
      chk("c_idle", registerWrite, 0);

      // Back-pressure with interleaved loads: order and count of writes
      wq.delete();
      alu_valid = 1'b1; alu_dest = 5'd10; alu_data = 32'hA0;
      load_issue = 1'b1; load_issue_dest = 5'd20;
      tick();
      alu_dest = 5'd11; alu_data = 32'hB1;
      load_issue = 1'b0; load_valid = 1'b1; load_data = 32'hD0;
      tick();
      alu_dest = 5'd12; alu_data = 32'hC2;
      load_valid = 1'b0; load_issue = 1'b1; load_issue_dest = 5'd21;
      #1 chk("d_full0", alu_ready, 0);
      tick();
      load_issue = 1'b0; load_valid = 1'b1; load_data = 32'hD1;
      #1 chk("d_free0", alu_ready, 1);
      tick();
      alu_dest = 5'd13; alu_data = 32'hD3;
      load_valid = 1'b0; load_issue = 1'b1; load_issue_dest = 5'd22;
      #1 chk("d_full1", alu_ready, 0);
      tick();
      load_issue = 1'b0; load_valid = 1'b1; load_data = 32'hD2;
      #1 chk("d_free1", alu_ready, 1);
      tick();
      alu_valid = 1'b0; load_valid = 1'b0;
      repeat (5) tick();
      chk("d_count", wq.size(), 7);
      for (int i = 0; i < 7 && i < wq.size(); i++) begin
         chk($sformatf("d_order%0d", i), wq[i], exp_d[i]);
      end

      // Destination 0 is dropped and never raises hazard
      wq.delete();
      alu_valid = 1'b1; alu_dest = 5'd0; alu_data = 32'hFFFF;
      tick();
      alu_valid = 1'b0; rsAddress = 5'd0; rtAddress = 5'd0;
      #1 chk("e_hazard", hazard, 0);
      repeat (3) tick();
      chk("e_no_write", wq.size(), 0);

      // Reset mid-load abandons it; stray response ignored
      load_issue = 1'b1; load_issue_dest = 5'd9;
      alu_valid = 1'b1; alu_dest = 5'd15; alu_data = 32'h55;
      tick();
      load_issue = 1'b0; alu_valid = 1'b0;
      #1 chk("f_wait", load_issue_ready, 0);
      tick();
      chk("f_pre_wr", {registerWrite, writeAddress}, {1'b1, 5'd15});
      rsAddress = 5'd9;
      #2 rst = 1'b0;
      #1 chk("f_rst_wr", registerWrite, 0);
      chk("f_rst_waddr", writeAddress, 0);
      chk("f_rst_wdata", writeData, 0);
      chk("f_rst_ready", load_issue_ready, 1);
      chk("f_rst_hazard", hazard, 0);
      chk("f_rst_alu_ready", alu_ready, 1);
      @(posedge clk);
      #1 rst = 1'b1;
      rsAddress = '0;
      load_valid = 1'b1; load_data = 32'hBEEF;
      tick();
      load_valid = 1'b0;
      #1 chk("f_stray_wr", registerWrite, 0);
      chk("f_idle_ready", load_issue_ready, 1);
      tick();
      chk("f_stray_wr2", registerWrite, 0);

      // Write-port bypass on rt for r9
      load_issue = 1'b1; load_issue_dest = 5'd9;
      tick();
      load_issue = 1'b0; load_valid = 1'b1; load_data = 32'h99;
      tick();
      load_valid = 1'b0; rsAddress = 5'd0; rtAddress = 5'd9;
      #1 chk("g_wr", {registerWrite, writeAddress, writeData}, {1'b1, 5'd9, 32'h99});
      chk("g_hit1", fwd_hit1, exp_fwd_hit);
      chk("g_data1", fwd_data1, exp_fwd_data);
      chk("g_hit0", fwd_hit0, 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter: ALU_Q_DEPTH, default 2, ALU result queue entries (power of two, >=2).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 alu_valid / alu_dest / alu_data  input  1/5/32  ALU result offer.
REQ-005 alu_ready  output  1  queue not full; transfer on alu_valid&&alu_ready.
REQ-006 load_issue / load_issue_dest  input  1/5  load sent to memory; reserves destination.
REQ-007 load_issue_ready  output  1  no load outstanding.
REQ-008 load_valid / load_data  input  1/32  memory load response, single-cycle pulse, always accepted.
REQ-009 rsAddress / rtAddress  input  5/5  decode-stage source registers for hazard check.
REQ-010 hazard  output  1  a source register has an unwritten pending result.
REQ-011 registerWrite / writeAddress / writeData  output  1/5/32  register file write port.
REQ-012 fwd_hit0 / fwd_hit1 / fwd_data0 / fwd_data1  output  1/1/32/32  bypass for rs/rt (see Configuration).

Function
REQ-013 Write port outputs SHALL be registered; a result selected in cycle N SHALL appear on the write port in cycle N+1 for exactly one cycle.
REQ-014 Arbitration per cycle: load response wins; else queue head is written; at most one write per cycle.
REQ-015 ALU results SHALL enter an ALU_Q_DEPTH FIFO; alu_ready SHALL be low when FIFO is full, combinationally ignoring same-cycle pop.
REQ-016 Empty FIFO, no load, alu_valid high: result SHALL still pass through the FIFO (no bypass), one-cycle enqueue plus REQ-013 latency.
REQ-017 Destination 0 results SHALL be consumed and dropped: no registerWrite pulse, no hazard contribution.
REQ-018 Load FSM states IDLE, WAIT: IDLE->WAIT on load_issue (latch dest); WAIT->IDLE on load_valid; load_issue_ready high only in IDLE.
REQ-019 load_issue in WAIT SHALL be ignored; load_valid in IDLE SHALL be ignored (no write).
REQ-020 load_issue and load_valid in the same WAIT cycle: response completes, new issue ignored.
REQ-021 hazard SHALL be high when nonzero rsAddress or rtAddress matches the WAIT load destination or any valid FIFO entry destination.
REQ-022 Same destination in FIFO and load: write order is arrival order at the write port; no reordering guarantee beyond REQ-014.
REQ-023 FIFO pointers SHALL wrap modulo ALU_Q_DEPTH with an explicit occupancy count 0..ALU_Q_DEPTH.

Reset
REQ-024 rst low SHALL immediately clear: FIFO count/pointers, FSM to IDLE, registerWrite=0, writeAddress=0, writeData=0, hazard=0, fwd_hit0/1=0, fwd_data0/1=0; alu_ready=1, load_issue_ready=1.
REQ-025 Reset mid-load SHALL abandon the load; a later stray load_valid SHALL be ignored.

Configuration
REQ-026 Macro WB_FORWARD_EN defined: fwd_hitX high and fwd_dataX = writeData when registerWrite and writeAddress matches nonzero rsAddress/rtAddress (current-cycle write-port bypass).
REQ-027 Macro undefined: fwd_hit0/1 and fwd_data0/1 SHALL be tied 0; no forwarding logic synthesized.

Structure
REQ-028 Shared package SHALL hold the 5-bit register address and 32-bit word typedefs, the load FSM state enum, and the zero-register constant.
REQ-029 FIFO SHALL be one sub-module, wb_result_fifo, parameterized by depth.

Verification
REQ-030 alu_valid dest=5 data=0x1234 at cycle 0 -> registerWrite, writeAddress=5, writeData=0x1234 at cycle 2.
REQ-031 load_issue dest=7; rsAddress=7 -> hazard=1 until load_valid data=0xCAFE; write r7=0xCAFE next cycle, hazard=0 after.
REQ-032 load_valid and queued ALU r3 same cycle -> load written first, r3 one cycle later.
REQ-033 ALU pushes with load responses every cycle, depth 2 -> alu_ready low after 2 entries, no result lost or duplicated.
REQ-034 alu dest=0 data=0xFFFF -> no registerWrite pulse; rsAddress=0 never asserts hazard.
REQ-035 rst low during WAIT, then load_valid -> no write, FSM IDLE, load_issue_ready=1; with WB_FORWARD_EN write r9 with rtAddress=9 -> fwd_hit1=1, fwd_data1=writeData.
